reaction_session_ctrl: RTL
==========================

Name: reaction_session_ctrl

Overview:
Session sequencer for the reaction-time tester. It runs NUM_ROUNDS consecutive rounds, issuing a per-round restart pulse to the delay generator and the BCD timing counter. For each round it classifies the outcome as valid, foul or timeout, captures the BCD time, and tracks the best time, foul count and timeout count. It sits between the player buttons and the delay-generator, BCD-counter and display datapath. Its round_start output is ORed into the datapath's counter/delay reset.

Parameters:
NUM_ROUNDS, 5, rounds per session (1..15).
PAUSE_MS, 1000, inter-round pause in tick_1khz ticks (1..65535).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  session-start button, debounced and synchronous; rising edge used
measure  input  1  player button, debounced and synchronous; rising edge used
led  input  1  stimulus LED from delay generator
tick_1khz  input  1  one-clk-wide 1 kHz tick
q2  input  4  BCD hundreds of running counter
q1  input  4  BCD tens
q0  input  4  BCD units
ceo  input  1  counter terminal count (999 reached)
round_start  output  1  one-cycle pulse; restarts delay generator and counter
round_num  output  4  current round, 1..NUM_ROUNDS; 0 when idle
last_bcd  output  12  last round result {h,t,u}
best_bcd  output  12  minimum valid time this session
best_valid  output  1  at least one valid round this session
round_result  output  2  00 none, 01 valid, 10 foul, 11 timeout
result_valid  output  1  one-cycle pulse when round_result/last_bcd update
foul_cnt  output  4  foul rounds this session
timeout_cnt  output  4  timeout rounds this session
busy  output  1  session in progress
done  output  1  session finished; held until next session or reset

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Edge detect: start_rise = start & ~start_d; measure_rise = measure & ~measure_d. Both _d registers reset to 0.
  - On reset, regardless of state: FSM goes to IDLE; all outputs go to 0, except best_bcd = 12'h999; pause counter clears.
- IDLE:
  - start_rise: round_num←1; clear foul_cnt, timeout_cnt and best_valid; best_bcd←999; last_bcd←0; round_result←00; → ARM.
- ARM:
  - round_start=1 for exactly this one cycle; → WAIT_LED.
  - The led input is ignored in ARM.
- WAIT_LED (priority top-down):
  - measure_rise & ~led: foul. last_bcd←12'h000, round_result←10, foul_cnt+1, result_valid pulse; → PAUSE.
  - measure_rise & led: valid. Capture {q2,q1,q0} and process as a TIMING capture.
  - led (no edge): → TIMING.
- TIMING (priority top-down):
  - measure_rise: valid. last_bcd←{q2,q1,q0}, round_result←01, result_valid pulse.
    - If ~best_valid or last < best_bcd: best_bcd←captured value, best_valid←1.
    - → PAUSE.
  - ceo (no edge): timeout. last_bcd←12'h999, round_result←11, timeout_cnt+1, result_valid pulse; best unchanged; → PAUSE.
  - measure_rise and ceo in the same cycle: measure wins.
- Best-time comparison:
  - Done as a 12-bit unsigned compare of packed BCD; valid BCD ordering equals binary ordering.
  - Ties do not update best_bcd.
- PAUSE:
  - Counts tick_1khz pulses.
  - When the count reaches PAUSE_MS:
    - If round_num==NUM_ROUNDS → DONE.
    - Otherwise round_num+1, → ARM.
  - measure edges are ignored. last_bcd and round_result hold.
- DONE:
  - done=1; round_num holds NUM_ROUNDS; statistics hold.
  - start_rise: restart the session exactly as from IDLE.
- Status outputs:
  - busy=1 in ARM, WAIT_LED, TIMING and PAUSE.
  - start_rise outside IDLE/DONE is ignored.
- Every round counts: a foul or timeout is not replayed. foul_cnt and timeout_cnt saturate at 15.
- Reset asserted mid-round: no further round_start pulse is issued.

Test Plan:
- Reset, then start_rise. Expect one round_start pulse 1 clk after the edge, round_num=1, busy=1, best_bcd=999, best_valid=0.
- Rounds with led high, then measure at q=3,4,7 (347) → last_bcd=347, round_result=01, best_bcd=347. Next round 215 → best=215. Next round 215 again → best stays 215; result_valid pulses 1 clk each.
- measure_rise while led=0 in round 2 → round_result=10, foul_cnt=1, last_bcd=000, best unchanged, round_num advances to 3 after PAUSE_MS ticks.
- led high, no measure, ceo=1 → round_result=11, last_bcd=999, timeout_cnt=1, best_valid unaffected. Same-cycle ceo+measure_rise at 998 → valid, last=998.
- NUM_ROUNDS=5 full session → done=1 and busy=0 after the 5th pause. start during the session is ignored. start_rise in DONE → counters clear, round_num=1, new round_start.
- reset asserted in TIMING and in PAUSE → IDLE, all outputs at reset values next clk, no round_start until a new start_rise.

Source files
------------

// File: rtl/reaction_session_ctrl.sv
// Session sequencer for the reaction-time tester: runs NUM_ROUNDS rounds,
// classifies each as valid/foul/timeout and keeps best time and error counts.
module reaction_session_ctrl #(
  parameter int NUM_ROUNDS = 5,
  parameter int PAUSE_MS   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        measure,
  input  logic        led,
  input  logic        tick_1khz,
  input  logic [3:0]  q2,
  input  logic [3:0]  q1,
  input  logic [3:0]  q0,
  input  logic        ceo,
  output logic        round_start,
  output logic [3:0]  round_num,
  output logic [11:0] last_bcd,
  output logic [11:0] best_bcd,
  output logic        best_valid,
  output logic [1:0]  round_result,
  output logic        result_valid,
  output logic [3:0]  foul_cnt,
  output logic [3:0]  timeout_cnt,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_LED, S_TIMING, S_PAUSE, S_DONE
  } state_t;

  localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [15:0] PAUSE_LAST = 16'(PAUSE_MS - 1);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  state_t      r_state, w_state_nxt;
  logic        r_start_d, r_measure_d;
  logic [15:0] r_pause_cnt;
  logic [3:0]  r_round_num, r_foul_cnt, r_timeout_cnt;
  logic [11:0] r_last_bcd, r_best_bcd;
  logic        r_best_valid, r_result_valid;
  logic [1:0]  r_round_result;

  logic        w_start_rise, w_measure_rise, w_pause_done, w_better;
  logic        w_init, w_capture, w_foul, w_timeout, w_round_adv;
  logic [11:0] w_cap_bcd;

  assign w_start_rise   = start & ~r_start_d;
  assign w_measure_rise = measure & ~r_measure_d;
  assign w_pause_done   = tick_1khz && (r_pause_cnt == PAUSE_LAST);
  assign w_cap_bcd      = {q2, q1, q0};
  // Packed BCD orders like binary, so a plain unsigned compare suffices; ties keep the old best.
  assign w_better       = ~r_best_valid || (w_cap_bcd < r_best_bcd);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_start_d   <= 1'b0;
      r_measure_d <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_start_d   <= start;
      r_measure_d <= measure;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    w_capture   = 1'b0;
    w_foul      = 1'b0;
    w_timeout   = 1'b0;
    w_round_adv = 1'b0;
    round_start = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_rise) begin
          w_init      = 1'b1;
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        round_start = 1'b1;
        w_state_nxt = S_WAIT_LED;
      end
      S_WAIT_LED: begin
        if (w_measure_rise && !led) begin
          w_foul      = 1'b1;
          w_state_nxt = S_PAUSE;
        end else if (w_measure_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = S_PAUSE;
        end else if (led) begin
          w_state_nxt = S_TIMING;
        end
      end
      S_TIMING: begin
        if (w_measure_rise) begin
          w_capture   = 1'b1;
          w_state_nxt = S_PAUSE;
        end else if (ceo) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (w_pause_done) begin
          if (r_round_num == LAST_ROUND) begin
            w_state_nxt = S_DONE;
          end else begin
            w_round_adv = 1'b1;
            w_state_nxt = S_ARM;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || r_state != S_PAUSE) begin
      r_pause_cnt <= 16'd0;
    end else if (tick_1khz) begin
      r_pause_cnt <= w_pause_done ? 16'd0 : r_pause_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_round_num    <= 4'd0;
      r_last_bcd     <= 12'h000;
      r_best_bcd     <= 12'h999;
      r_best_valid   <= 1'b0;
      r_round_result <= 2'b00;
      r_result_valid <= 1'b0;
      r_foul_cnt     <= 4'd0;
      r_timeout_cnt  <= 4'd0;
    end else begin
      r_result_valid <= w_capture | w_foul | w_timeout;
      if (w_init) begin
        r_round_num    <= 4'd1;
        r_last_bcd     <= 12'h000;
        r_best_bcd     <= 12'h999;
        r_best_valid   <= 1'b0;
        r_round_result <= 2'b00;
        r_foul_cnt     <= 4'd0;
        r_timeout_cnt  <= 4'd0;
      end
      if (w_round_adv) r_round_num <= r_round_num + 4'd1;
      if (w_capture) begin
        r_last_bcd     <= w_cap_bcd;
        r_round_result <= 2'b01;
        if (w_better) begin
          r_best_bcd   <= w_cap_bcd;
          r_best_valid <= 1'b1;
        end
      end
      if (w_foul) begin
        r_last_bcd     <= 12'h000;
        r_round_result <= 2'b10;
        r_foul_cnt     <= sat_inc4(r_foul_cnt);
      end
      if (w_timeout) begin
        r_last_bcd     <= 12'h999;
        r_round_result <= 2'b11;
        r_timeout_cnt  <= sat_inc4(r_timeout_cnt);
      end
    end
  end

  assign round_num    = r_round_num;
  assign last_bcd     = r_last_bcd;
  assign best_bcd     = r_best_bcd;
  assign best_valid   = r_best_valid;
  assign round_result = r_round_result;
  assign result_valid = r_result_valid;
  assign foul_cnt     = r_foul_cnt;
  assign timeout_cnt  = r_timeout_cnt;
  assign busy         = (r_state == S_ARM) || (r_state == S_WAIT_LED) ||
                        (r_state == S_TIMING) || (r_state == S_PAUSE);
  assign done         = (r_state == S_DONE);

endmodule
